// File: rtl/graphics_pkg.sv
// Shared definitions for the screen rectangle scanner: FSM state encoding and
// default framebuffer geometry.
package graphics_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_SKIP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_SCREEN_W   = 160;
  localparam int DEFAULT_SCREEN_H   = 120;
  localparam int DEFAULT_ADDR_WIDTH = 15;

endpackage

// File: rtl/screen_rect_scanner_if.sv
// Client + framebuffer bus of the scanner. slave = scanner view, master = the
// client/RAM side that drives requests, the new colour and read data.
interface screen_rect_scanner_if #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int ADDR_WIDTH   = 15
);
  logic                    screen_start;
  logic [WIDTH-1:0]        screen_x_min;
  logic [WIDTH-1:0]        screen_y_min;
  logic [WIDTH-1:0]        screen_x_range;
  logic [WIDTH-1:0]        screen_y_range;
  logic [COLOUR_WIDTH-1:0] new_screen_colour;
  logic [WIDTH-1:0]        screen_x;
  logic [WIDTH-1:0]        screen_y;
  logic [COLOUR_WIDTH-1:0] old_screen_colour;
  logic                    screen_done;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [COLOUR_WIDTH-1:0] mem_wdata;
  logic                    mem_we;
  logic [COLOUR_WIDTH-1:0] mem_rdata;

  modport slave (
    input  screen_start, screen_x_min, screen_y_min, screen_x_range,
           screen_y_range, new_screen_colour, mem_rdata,
    output screen_x, screen_y, old_screen_colour, screen_done,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output screen_start, screen_x_min, screen_y_min, screen_x_range,
           screen_y_range, new_screen_colour, mem_rdata,
    input  screen_x, screen_y, old_screen_colour, screen_done,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/screen_rect_scanner_raster_counter.sv
// raster_counter: x/y nested counter over a latched rectangle. Ends are held in
// WIDTH+1 bits so wide rectangles run past 2^WIDTH-1 instead of wrapping.
module raster_counter #(
  parameter int WIDTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter bit CLIP     = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] x_min,
  input  logic [WIDTH-1:0] y_min,
  input  logic [WIDTH-1:0] x_range,
  input  logic [WIDTH-1:0] y_range,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             last,
  output logic             load_vis,
  output logic             step_vis
);
  localparam int CW = WIDTH + 1;

  logic [WIDTH-1:0] x_min_q;
  logic [CW-1:0]    x_end_q, y_end_q;
  logic [CW-1:0]    x_q, y_q;
  logic [CW-1:0]    step_x, step_y;
  logic             x_wrap;

  // Visibility of a pixel; always true when clipping is compiled out.
  function automatic logic on_screen(input logic [CW-1:0] px, input logic [CW-1:0] py);
    return !CLIP || ((px < CW'(SCREEN_W)) && (py < CW'(SCREEN_H)));
  endfunction

  always_comb begin
    x_wrap = (x_q == x_end_q);
    step_x = x_wrap ? {1'b0, x_min_q} : x_q + CW'(1);
    step_y = x_wrap ? y_q + CW'(1) : y_q;
  end

  assign last     = x_wrap && (y_q == y_end_q);
  assign load_vis = on_screen({1'b0, x_min}, {1'b0, y_min});
  assign step_vis = on_screen(step_x, step_y);
  assign x        = x_q[WIDTH-1:0];
  assign y        = y_q[WIDTH-1:0];

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_min_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (load) begin
      x_min_q <= x_min;
      x_end_q <= {1'b0, x_min} + {1'b0, x_range};
      y_end_q <= {1'b0, y_min} + {1'b0, y_range};
      x_q     <= {1'b0, x_min};
      y_q     <= {1'b0, y_min};
    end else if (step) begin
      x_q <= step_x;
      y_q <= step_y;
    end
  end
endmodule

// File: rtl/screen_rect_scanner.sv
// Walks a rectangle in raster order, read-modify-writing each framebuffer pixel
// through the client. Define SCREEN_RECT_SCANNER_CLIP_EN to skip off-screen pixels.
module screen_rect_scanner
  import graphics_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = DEFAULT_SCREEN_W,
  parameter int SCREEN_H     = DEFAULT_SCREEN_H,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input logic                  clock,
  input logic                  reset,
  screen_rect_scanner_if.slave bus
);
`ifdef SCREEN_RECT_SCANNER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  state_t           state;
  logic             armed;
  logic             load, step, last, load_vis, step_vis;
  logic [WIDTH-1:0] x, y;
  logic [ADDR_WIDTH-1:0] pix_addr;

  assign load = (state == S_IDLE) && bus.screen_start && armed;
  assign step = ((state == S_WRITE) || (state == S_SKIP)) && !last;

  raster_counter #(
    .WIDTH   (WIDTH),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .CLIP    (CLIP_EN)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .x_min   (bus.screen_x_min),
    .y_min   (bus.screen_y_min),
    .x_range (bus.screen_x_range),
    .y_range (bus.screen_y_range),
    .x       (x),
    .y       (y),
    .last    (last),
    .load_vis(load_vis),
    .step_vis(step_vis)
  );

  // armed drops on acceptance and only returns once start is seen low in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      armed <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            armed <= 1'b0;
            state <= load_vis ? S_READ : S_SKIP;
          end else if (!bus.screen_start) begin
            armed <= 1'b1;
          end
        end
        S_READ:          state <= S_WRITE;
        S_WRITE, S_SKIP: state <= last ? S_DONE : (step_vis ? S_READ : S_SKIP);
        S_DONE:          state <= S_IDLE;
        default:         state <= S_IDLE;
      endcase
    end
  end

  assign pix_addr = ADDR_WIDTH'(y) * ADDR_WIDTH'(SCREEN_W) + ADDR_WIDTH'(x);

  // NOTE: every output gets a default first so this block cannot infer latches.
  always_comb begin
    bus.screen_x          = x;
    bus.screen_y          = y;
    bus.old_screen_colour = '0;
    bus.screen_done       = 1'b0;
    bus.mem_addr          = '0;
    bus.mem_wdata         = '0;
    bus.mem_we            = 1'b0;
    case (state)
      S_READ: bus.mem_addr = pix_addr;
      S_WRITE: begin
        bus.mem_addr          = pix_addr;
        bus.old_screen_colour = bus.mem_rdata;
        bus.mem_wdata         = bus.new_screen_colour;
        bus.mem_we            = 1'b1;
      end
      S_DONE:  bus.screen_done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_screen_rect_scanner.sv
// Directed bench for screen_rect_scanner with a synchronous-read framebuffer
// model and a configurable combinational client.
module tb_screen_rect_scanner;
  logic clk;
  logic rst_n;

  screen_rect_scanner_if bus ();

  screen_rect_scanner dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Framebuffer model with a bench-side load port used only while the DUT idles.
  logic [2:0]  ram [0:32767];
  logic        tb_we;
  logic [14:0] tb_addr;
  logic [2:0]  tb_data;

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Client: 0 = old+1, 1 = constant 6, 2 = pass-through.
  int client_mode;
  always_comb begin
    case (client_mode)
      0:       bus.new_screen_colour = bus.old_screen_colour + 3'd1;
      1:       bus.new_screen_colour = 3'd6;
      default: bus.new_screen_colour = bus.old_screen_colour;
    endcase
  end

  int wa[$];
  int wd[$];
  int done_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa.push_back(int'(bus.mem_addr));
      wd.push_back(int'(bus.mem_wdata));
    end
    if (bus.screen_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [2:0] pat(input int a);
    return 3'((a * 3 + 1) % 8);
  endfunction

  task automatic fill(input int a, input logic [2:0] d);
    tb_we   = 1'b1;
    tb_addr = 15'(a);
    tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic begin_scan(input int xm, input int ym, input int xr, input int yr);
    bus.screen_x_min   = 8'(xm);
    bus.screen_y_min   = 8'(ym);
    bus.screen_x_range = 8'(xr);
    bus.screen_y_range = 8'(yr);
    bus.screen_start   = 1'b1;
  endtask

  // Cycle 1 is the cycle after the accepting edge; returns -1 if done never rises.
  task automatic run_scan(input int max_cyc, output int done_cyc, output int we_err);
    done_cyc = -1;
    we_err   = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (bus.mem_we !== ((c % 2) == 0 && bus.screen_done !== 1'b1)) we_err++;
      if (bus.screen_done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    if (done_cyc < 0) $display("FAIL scan_timeout: no done within %0d cycles", max_cyc);
  endtask

  task automatic finish_scan();
    bus.screen_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.screen_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.screen_done); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 3'd0) begin n_fail++; $display("FAIL reset_wdata: got %0d want 0", bus.mem_wdata); end
    n_checks++; if (bus.screen_x !== 8'd0 || bus.screen_y !== 8'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 0,0", bus.screen_x, bus.screen_y); end
    n_checks++; if (bus.old_screen_colour !== 3'd0) begin n_fail++; $display("FAIL reset_old: got %0d want 0", bus.old_screen_colour); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_pixel();
    int dc, we_err, wb;
    client_mode = 0;
    fill(1125, 3'd3);
    wb = wa.size();
    begin_scan(5, 7, 0, 0);
    run_scan(20, dc, we_err);
    n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL single_done_cycle: got %0d want 3", dc); end
    n_checks++; if (wa.size() - wb !== 1) begin n_fail++; $display("FAIL single_write_count: got %0d want 1", wa.size() - wb); end
    if (wa.size() > wb) begin
      n_checks++; if (wa[wb] !== 1125) begin n_fail++; $display("FAIL single_addr: got %0d want 1125", wa[wb]); end
      n_checks++; if (wd[wb] !== 4) begin n_fail++; $display("FAIL single_data: got %0d want 4", wd[wb]); end
    end
    n_checks++; if (ram[1125] !== 3'd4) begin n_fail++; $display("FAIL single_ram: got %0d want 4", ram[1125]); end
    finish_scan();
  endtask

  task automatic test_rect_3x2();
    int dc, we_err, wb;
    int exp_a[6] = '{3210, 3211, 3212, 3370, 3371, 3372};
    client_mode = 1;
    wb = wa.size();
    begin_scan(10, 20, 2, 1);
    run_scan(40, dc, we_err);
    n_checks++; if (dc !== 13) begin n_fail++; $display("FAIL rect_done_cycle: got %0d want 13", dc); end
    n_checks++; if (we_err !== 0) begin n_fail++; $display("FAIL rect_we_pattern: got %0d bad cycles want 0", we_err); end
    n_checks++; if (wa.size() - wb !== 6) begin n_fail++; $display("FAIL rect_write_count: got %0d want 6", wa.size() - wb); end
    for (int i = 0; i < 6; i++) begin
      if (wa.size() > wb + i) begin
        n_checks++; if (wa[wb+i] !== exp_a[i] || wd[wb+i] !== 6) begin
          n_fail++; $display("FAIL rect_write%0d: got addr %0d data %0d want addr %0d data 6", i, wa[wb+i], wd[wb+i], exp_a[i]);
        end
      end
    end
    finish_scan();
  endtask

  task automatic test_pass_through();
    int px, py, a, k, bad;
    logic [2:0] exp_old;
    client_mode = 2;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) fill((40 + j) * 160 + 30 + i, pat((40 + j) * 160 + 30 + i));
    begin_scan(30, 40, 3, 3);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c <= 32) begin
        k  = (c - 1) / 2;
        px = 30 + k % 4;
        py = 40 + k / 4;
        n_checks++; if (bus.screen_x !== 8'(px) || bus.screen_y !== 8'(py)) begin
          n_fail++; $display("FAIL pass_xy c%0d: got %0d,%0d want %0d,%0d", c, bus.screen_x, bus.screen_y, px, py);
        end
        exp_old = (c % 2 == 0) ? pat(py * 160 + px) : 3'd0;
        n_checks++; if (bus.old_screen_colour !== exp_old) begin
          n_fail++; $display("FAIL pass_old c%0d: got %0d want %0d", c, bus.old_screen_colour, exp_old);
        end
      end else begin
        n_checks++; if (bus.screen_done !== 1'b1) begin n_fail++; $display("FAIL pass_done: got %b want 1 at cycle 33", bus.screen_done); end
      end
    end
    bad = 0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) begin
        a = (40 + j) * 160 + 30 + i;
        if (ram[a] !== pat(a)) bad++;
      end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL pass_ram: got %0d changed pixels want 0", bad); end
    finish_scan();
  endtask

  task automatic test_rearm();
    int dc, we_err, wb, db;
    client_mode = 1;
    wb = wa.size();
    db = done_cnt;
    begin_scan(0, 0, 1, 1);
    repeat (40) @(negedge clk);
    n_checks++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL rearm_held_done: got %0d pulses want 1", done_cnt - db); end
    n_checks++; if (wa.size() - wb !== 4) begin n_fail++; $display("FAIL rearm_held_writes: got %0d want 4", wa.size() - wb); end
    bus.screen_start = 1'b0;
    @(negedge clk);
    bus.screen_start = 1'b1;
    run_scan(30, dc, we_err);
    n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL rearm_second_done_cycle: got %0d want 9", dc); end
    n_checks++; if (wa.size() - wb !== 8) begin n_fail++; $display("FAIL rearm_total_writes: got %0d want 8", wa.size() - wb); end
    finish_scan();
  endtask

  task automatic test_reset_mid_scan();
    int dc, we_err, wb, db;
    client_mode = 1;
    wb = wa.size();
    db = done_cnt;
    begin_scan(50, 60, 3, 3);
    repeat (8) @(negedge clk);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we: got %b want 1", bus.mem_we); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0 || bus.screen_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got we %b done %b want 0 0", bus.mem_we, bus.screen_done);
    end
    bus.screen_start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wa.size() - wb !== 3) begin n_fail++; $display("FAIL midrst_writes: got %0d want 3", wa.size() - wb); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt - db !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - db); end
    wb = wa.size();
    begin_scan(70, 80, 0, 0);
    run_scan(20, dc, we_err);
    n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL midrst_restart_done: got %0d want 3", dc); end
    n_checks++; if (wa.size() - wb !== 1 || (wa.size() > wb && wa[wb] !== 12870)) begin
      n_fail++; $display("FAIL midrst_restart_addr: got count %0d want 1 at addr 12870", wa.size() - wb);
    end
    finish_scan();
  endtask

`ifdef SCREEN_RECT_SCANNER_CLIP_EN
  task automatic test_edge();
    int dc, we_err, wb;
    client_mode = 1;
    wb = wa.size();
    begin_scan(158, 119, 3, 1);
    run_scan(40, dc, we_err);
    n_checks++; if (dc !== 11) begin n_fail++; $display("FAIL clip_done_cycle: got %0d want 11", dc); end
    n_checks++; if (wa.size() - wb !== 2) begin n_fail++; $display("FAIL clip_write_count: got %0d want 2", wa.size() - wb); end
    if (wa.size() >= wb + 2) begin
      n_checks++; if (wa[wb] !== 19198 || wa[wb+1] !== 19199) begin
        n_fail++; $display("FAIL clip_addrs: got %0d,%0d want 19198,19199", wa[wb], wa[wb+1]);
      end
    end
    finish_scan();
  endtask
`else
  task automatic test_edge();
    int dc, we_err, wb;
    int exp_a[4] = '{19038, 19039, 19198, 19199};
    client_mode = 1;
    wb = wa.size();
    begin_scan(158, 118, 1, 1);
    run_scan(40, dc, we_err);
    n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL edge_done_cycle: got %0d want 9", dc); end
    n_checks++; if (wa.size() - wb !== 4) begin n_fail++; $display("FAIL edge_write_count: got %0d want 4", wa.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      if (wa.size() > wb + i) begin
        n_checks++; if (wa[wb+i] !== exp_a[i]) begin
          n_fail++; $display("FAIL edge_addr%0d: got %0d want %0d", i, wa[wb+i], exp_a[i]);
        end
      end
    end
    finish_scan();
  endtask
`endif

  initial begin
    tb_we              = 1'b0;
    tb_addr            = '0;
    tb_data            = '0;
    client_mode        = 0;
    bus.screen_start   = 1'b0;
    bus.screen_x_min   = '0;
    bus.screen_y_min   = '0;
    bus.screen_x_range = '0;
    bus.screen_y_range = '0;
    rst_n              = 1'b0;
    test_reset();
    test_single_pixel();
    test_rect_3x2();
    test_pass_through();
    test_rearm();
    test_reset_mid_scan();
    test_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
